// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial add/subtract unit. A single full-adder cell and a carry
// flip-flop process one operand bit per clock, LSB first. A start request in
// IDLE latches both operands. In subtract mode, B is latched inverted and the
// carry seed is inverted, giving A + ~B + ~Cin == A - B - Cin.
//
// Timing (accepting edge = k):
//   edge k            : operands latched, Busy rises
//   edges k+1..k+W    : one result bit per edge
//   edge k+W          : Sum/Cout/Ovf updated, Busy falls, Done rises
//   edge k+W+1        : Done falls, back to IDLE
//
// Parameters:
//   WIDTH    operand/result width in bits (>= 1)
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset, highest priority
//   start_i  request a new operation; only honoured in IDLE
//   a_i      operand A, sampled on the accepting edge
//   b_i      operand B, sampled on the accepting edge
//   cin_i    carry-in (add) / borrow-in (sub), sampled on the accepting edge
//   sub_i    0 = add, 1 = subtract, sampled on the accepting edge
//   busy_o   high while result bits are being produced
//   done_o   one-cycle pulse when sum_o/cout_o/ovf_o are updated
//   sum_o    registered result, modulo 2^WIDTH
//   cout_o   carry-out; in subtract mode 1 = no borrow
//   ovf_o    two's-complement signed overflow
// -----------------------------------------------------------------------------

// Protocol checker for the serial adder control signals.
module serial_adder_chk #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          busy_i,
  input logic          done_i,
  input logic          sub_i,
  input logic [CW-1:0] cnt_i
);

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Busy and Done are mutually exclusive phases of one operation.
  a_busy_done_excl : assert property (@(posedge clk_i) disable iff (rst_i)
    !(busy_i && done_i));

  // Done is a single-cycle pulse.
  a_done_pulse : assert property (@(posedge clk_i) disable iff (rst_i)
    done_i |=> !done_i);

  // The latched mode bit cannot change while bits are being processed.
  a_sub_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    busy_i |=> (!busy_i || $stable(sub_i)));

  // The bit counter stays within the operand while running.
  a_cnt_range : assert property (@(posedge clk_i) disable iff (rst_i)
    busy_i |-> (cnt_i <= CNT_LAST));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  // One extra counter bit so the count can step past WIDTH-1 without wrapping.
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             sub_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             s_d;
  logic             c_d;
  logic             last_d;
  logic [WIDTH-1:0] res_d;

  // Full-adder sum output.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Full-adder carry output (majority of the three inputs).
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Single full-adder cell operating on the current LSBs and the carry flop.
  always_comb begin
    s_d    = fa_sum(a_q[0], b_q[0], c_q);
    c_d    = fa_carry(a_q[0], b_q[0], c_q);
    last_d = (cnt_q == CNT_LAST);
  end

  // New result bit enters at the MSB end so that after WIDTH shifts bit 0 of
  // the first step has reached bit 0 of the register.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_d = s_d;
    end else begin : g_res_wn
      assign res_d = {s_d, res_q[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM, operand/result shifters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            // Subtraction as A + ~B + ~Cin: invert B and the carry seed.
            b_q     <= b_i ^ {WIDTH{sub_i}};
            c_q     <= cin_i ^ sub_i;
            sub_q   <= sub_i;
            res_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          a_q   <= a_q >> 1'b1;
          b_q   <= b_q >> 1'b1;
          c_q   <= c_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (last_d) begin
            // Carry into the MSB is the carry flop at this step; overflow is
            // its disagreement with the carry out of the MSB.
            sum_q   <= res_d;
            cout_q  <= c_d;
            ovf_q   <= c_q ^ c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

  serial_adder_chk #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .busy_i (busy_q),
    .done_i (done_q),
    .sub_i  (sub_q),
    .cnt_i  (cnt_q)
  );

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder at WIDTH = 8, 1 and 16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8 instance
  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  // WIDTH = 1 instance
  logic       start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = 1'b0, b1 = 1'b0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  // WIDTH = 16 instance
  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8),
    .cin_i(cin8), .sub_i(sub8), .busy_o(busy8), .done_o(done8),
    .sum_o(sum8), .cout_o(cout8), .ovf_o(ovf8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1),
    .cin_i(cin1), .sub_i(sub1), .busy_o(busy1), .done_o(done1),
    .sum_o(sum1), .cout_o(cout1), .ovf_o(ovf1)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .a_i(a16), .b_i(b16),
    .cin_i(cin16), .sub_i(sub16), .busy_o(busy16), .done_o(done16),
    .sum_o(sum16), .cout_o(cout16), .ovf_o(ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit operation, scramble the inputs after acceptance, and
  // wait for Done. lat = edges from accept to Done, bcnt = cycles Busy seen.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      output int lat, output int bcnt);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run1(input logic a, input logic b, input logic cin, input logic sub,
                      output int lat, output int bcnt);
    a1 = a; b1 = b; cin1 = cin; sub1 = sub; start1 = 1'b1;
    tick();
    start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~cin; sub1 = ~sub;
    lat = 0; bcnt = 0;
    while (!done1 && lat < 40) begin
      if (busy1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output int lat, output int bcnt);
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1'b1;
    tick();
    start16 = 1'b0; a16 = ~a; b16 = ~b; cin16 = ~cin; sub16 = ~sub;
    lat = 0; bcnt = 0;
    while (!done16 && lat < 60) begin
      if (busy16) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum8: got %h want 00", sum8); end
    checks++; if ({cout8, ovf8} !== 2'b00) begin errors++; $display("FAIL reset_flags8: got %b want 00", {cout8, ovf8}); end
    checks++; if ({busy1, done1, sum1, cout1, ovf1} !== 5'b00000) begin errors++; $display("FAIL reset_w1: got %b want 00000", {busy1, done1, sum1, cout1, ovf1}); end
    checks++; if ({busy16, done16, cout16, ovf16} !== 4'b0000 || sum16 !== 16'h0000) begin errors++; $display("FAIL reset_w16: got %b/%h want 0000/0000", {busy16, done16, cout16, ovf16}, sum16); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int lat, bcnt;
    run8(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt);
    checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency: got %0d want 8", lat); end
    checks++; if (bcnt !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d want 8", bcnt); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL add_sum: got %h want 00", sum8); end
    checks++; if (cout8 !== 1'b1) begin errors++; $display("FAIL add_cout: got %b want 1", cout8); end
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b want 0", ovf8); end
    tick();
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done8); end
    checks++; if (sum8 !== 8'h00 || cout8 !== 1'b1) begin errors++; $display("FAIL add_hold: got %h/%b want 00/1", sum8, cout8); end
  endtask

  task automatic test_overflow();
    int lat, bcnt;
    run8(8'h7F, 8'h01, 1'b0, 1'b0, lat, bcnt);
    checks++; if (lat !== 8) begin errors++; $display("FAIL ovf_add_latency: got %0d want 8", lat); end
    checks++; if ({sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_add: got sum %h cout %b ovf %b want 80 0 1", sum8, cout8, ovf8); end
    tick();
    run8(8'h05, 8'h07, 1'b0, 1'b1, lat, bcnt);
    checks++; if ({sum8, cout8, ovf8} !== {8'hFE, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_borrow: got sum %h cout %b ovf %b want FE 0 0", sum8, cout8, ovf8); end
    tick();
  endtask

  task automatic test_sub();
    int lat, bcnt;
    run8(8'h80, 8'h01, 1'b0, 1'b1, lat, bcnt);
    checks++; if ({sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_ovf: got sum %h cout %b ovf %b want 7F 1 1", sum8, cout8, ovf8); end
    tick();
    run8(8'h10, 8'h03, 1'b1, 1'b1, lat, bcnt);
    checks++; if (lat !== 8) begin errors++; $display("FAIL sub_cin_latency: got %0d want 8", lat); end
    checks++; if ({sum8, cout8, ovf8} !== {8'h0C, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_cin: got sum %h cout %b ovf %b want 0C 1 0", sum8, cout8, ovf8); end
    tick();
  endtask

  // Start held high with operands changing every cycle: operations are
  // accepted at loop edges 0, 10, 20, 30 and complete at edges 8, 18, 28.
  task automatic test_back_to_back();
    logic [7:0] exp_sum [3];
    int         exp_edge [3];
    int         ndone;
    logic [7:0] last;
    exp_sum[0] = 8'h10; exp_edge[0] = 8;   // 10 + 00
    exp_sum[1] = 8'h24; exp_edge[1] = 18;  // 1A + 0A
    exp_sum[2] = 8'h38; exp_edge[2] = 28;  // 24 + 14
    ndone = 0;
    last  = sum8;
    cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    for (int j = 0; j < 32; j++) begin
      a8 = 8'h10 + 8'(j);
      b8 = 8'(j);
      tick();
      if (done8) begin
        if (ndone < 3) begin
          checks++; if (j !== exp_edge[ndone]) begin errors++; $display("FAIL b2b_done_edge%0d: got %0d want %0d", ndone, j, exp_edge[ndone]); end
          checks++; if ({sum8, cout8, ovf8} !== {exp_sum[ndone], 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_result%0d: got %h %b %b want %h 0 0", ndone, sum8, cout8, ovf8, exp_sum[ndone]); end
        end
        ndone++;
        last = sum8;
      end else begin
        checks++; if (sum8 !== last) begin errors++; $display("FAIL b2b_hold_edge%0d: got %h want %h", j, sum8, last); end
      end
    end
    start8 = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", ndone); end
    repeat (12) tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt, nd;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL midrst_ctrl: got %b want 00", {busy8, done8}); end
    checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h want 00", sum8); end
    checks++; if ({cout8, ovf8} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b want 00", {cout8, ovf8}); end
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles want 0", nd); end
    run8(8'h03, 8'h04, 1'b0, 1'b0, lat, bcnt);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_restart_latency: got %0d want 8", lat); end
    checks++; if (sum8 !== 8'h07) begin errors++; $display("FAIL midrst_restart_sum: got %h want 07", sum8); end
    tick();
  endtask

  task automatic test_width1();
    int lat, bcnt;
    run1(1'b1, 1'b1, 1'b1, 1'b0, lat, bcnt);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w1_latency: got %0d want 1", lat); end
    checks++; if (bcnt !== 1) begin errors++; $display("FAIL w1_busy_cycles: got %0d want 1", bcnt); end
    checks++; if ({sum1, cout1, ovf1} !== 3'b110) begin errors++; $display("FAIL w1_add: got %b want 110", {sum1, cout1, ovf1}); end
    tick();
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL w1_done_pulse: got %b want 0", done1); end
    // 0 - 1 in one signed bit: result 1, borrow, overflow.
    run1(1'b0, 1'b1, 1'b0, 1'b1, lat, bcnt);
    checks++; if ({sum1, cout1, ovf1} !== 3'b101) begin errors++; $display("FAIL w1_sub: got %b want 101", {sum1, cout1, ovf1}); end
    tick();
  endtask

  task automatic test_width16();
    int lat, bcnt;
    run16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, bcnt);
    checks++; if (lat !== 16) begin errors++; $display("FAIL w16_latency: got %0d want 16", lat); end
    checks++; if (bcnt !== 16) begin errors++; $display("FAIL w16_busy_cycles: got %0d want 16", bcnt); end
    checks++; if (sum16 !== 16'hFFFE) begin errors++; $display("FAIL w16_sum: got %h want FFFE", sum16); end
    checks++; if ({cout16, ovf16} !== 2'b10) begin errors++; $display("FAIL w16_flags: got %b want 10", {cout16, ovf16}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_back_to_back();
    test_sub();
    test_reset_mid_run();
    test_width1();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d errors so far", errors);
    $fatal(1);
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial add/subtract unit; successor to the combinational half-adder cell.
- Latches two WIDTH-bit operands on a Start pulse and computes A+B+Cin or A-B-Cin.
- Uses one full-adder cell and a carry flip-flop, processing one bit per clock, LSB first.
- Serves as an area-cheap arithmetic unit for multi-cycle datapaths; results are held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; accepted only in IDLE.
- A  input  WIDTH  operand A, sampled on the accepting edge.
- B  input  WIDTH  operand B, sampled on the accepting edge.
- Cin  input  1  carry-in (add) or borrow-in (sub), sampled on the accepting edge.
- Sub  input  1  0 = add, 1 = subtract; sampled on the accepting edge.
- Busy  output  1  high while bits are being processed (RUN).
- Done  output  1  one-cycle pulse: Sum, Cout and Ovf are valid and updated.
- Sum  output  WIDTH  registered result.
- Cout  output  1  carry-out; in subtract mode 1 = no borrow, 0 = borrow.
- Ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: state=IDLE; Busy=0, Done=0, Sum=0, Cout=0, Ovf=0; operand shift registers, carry flip-flop and bit counter are cleared.
- Reset has priority over every other event, including mid-RUN. An in-flight operation is abandoned and no Done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at edge k latches A and B^{WIDTH{Sub}} into shift registers.
  - Carry flip-flop is loaded with Cin^Sub; Sub is latched.
  - Counter is cleared; state goes to RUN and Busy=1 from edge k.
  - Start=0 leaves the state in IDLE.
- RUN:
  - Each edge k+1..k+WIDTH computes bit i: s = a0^b0^c; c' = majority(a0,b0,c).
  - s is shifted into the MSB end of the result register; operands shift right; counter increments.
  - At edge k+WIDTH the final bit completes; state goes to DONE.
  - Sum, Cout and Ovf are registered; Busy falls; Done rises.
- Ovf = carry into MSB XOR carry out of MSB, using the inverted-B operand in Sub mode.
- DONE: Done=1 for exactly one cycle (edge k+WIDTH to edge k+WIDTH+1), then unconditional return to IDLE.
- Latency: Start edge to Done assertion = WIDTH cycles. Minimum Start-to-Start spacing = WIDTH+2 cycles.
- Start while in RUN or DONE is ignored (no queuing).
- Changes on A, B, Cin or Sub after the accepting edge have no effect on the result.
- Sum, Cout and Ovf hold their last values through IDLE and through the next RUN until that operation's DONE. No partial results are ever visible.
- Wrap-around: the result is modulo 2^WIDTH; the carry is reported only on Cout.
- WIDTH=1: RUN lasts one cycle; Ovf = Cin_to_msb ^ Cout with the MSB = bit 0.
- Counter width is clog2(WIDTH)+1 so that counter == WIDTH-1 is detectable without overflow.

Test Plan:
- WIDTH=8, A=FF, B=01, Cin=0, Sub=0 -> Done exactly 8 cycles after the Start edge; Sum=00, Cout=1, Ovf=0; Busy high for exactly 8 cycles.
- WIDTH=8, A=7F, B=01, Cin=0, Sub=0 -> Sum=80, Cout=0, Ovf=1. Then A=05, B=07, Sub=1, Cin=0 -> Sum=FE, Cout=0, Ovf=0.
- WIDTH=8, A=80, B=01, Sub=1, Cin=0 -> Sum=7F, Cout=1, Ovf=1. Then A=10, B=03, Sub=1, Cin=1 -> Sum=0C, Cout=1, Ovf=0.
- Start held high continuously while A and B toggle every cycle during RUN -> exactly one Done per WIDTH+2 cycles. Each result matches the operands sampled at the accepting edge; Sum is unchanged between Done pulses.
- rst=1 asserted at the 4th RUN cycle -> next cycle Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, and no Done appears. A new Start (A=03, B=04) -> Sum=07 after 8 cycles.
- WIDTH=1, A=1, B=1, Cin=1, Sub=0 -> Done 1 cycle after Start; Sum=1, Cout=1, Ovf=0. WIDTH=16, A=FFFF, B=FFFF -> Sum=FFFE, Cout=1, Done after 16 cycles.
